// File: rtl/dma_xfer_sequencer.sv
// Control sequencer for a four-channel 8237-style DMA datapath.
// Arbitrates requests, runs the HRQ/HLDA handshake, steps SI/S0..S4 and
// keeps per-channel word counts with terminal-count (TC) generation.
// Optional feature: define DMA_AUTOINIT_EN to add the autoinit port and
// per-channel base registers that reload the count at TC.
// Count update, TC flags and the eop pulse are registered on the edge that
// enters S4, so they are visible during the S4 cycle; a wc_load sampled on
// that same edge for the active channel wins over the decrement.
module dma_xfer_sequencer #(
  parameter int unsigned NCH = 4,
  parameter int unsigned WCW = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [NCH-1:0]   DREQ,
  input  logic             HLDA,
  input  logic             EOP_N_IN,
  input  logic [NCH-1:0]   mask,
  input  logic             rot_pri,
  input  logic [2*NCH-1:0] xfer_type,
  input  logic [NCH-1:0]   wc_load,
  input  logic [WCW-1:0]   wc_data,
`ifdef DMA_AUTOINIT_EN
  input  logic [NCH-1:0]   autoinit,
`endif
  output logic             HRQ,
  output logic [NCH-1:0]   DACK,
  output logic             aen,
  output logic             adstb,
  output logic             ior,
  output logic             iow,
  output logic             memr,
  output logic             memw,
  output logic             eop,
  output logic [NCH-1:0]   tc_status,
  output logic             addr_step,
  output logic [1:0]       active_ch
);

  typedef enum logic [2:0] {StSi, StS0, StS1, StS2, StS3, StS4} state_e;

  state_e         state_q;
  logic [WCW-1:0] count_q [NCH];
`ifdef DMA_AUTOINIT_EN
  logic [WCW-1:0] base_q [NCH];
`endif
  logic [NCH-1:0] tc_mask_q;
  logic [1:0]     rot_ptr_q;
  logic           eop_latch_q;

  logic [NCH-1:0] elig;
  logic [1:0]     win;
  logic           win_valid;
  logic [1:0]     start;
  logic [1:0]     idx;
  logic [1:0]     ch_type;
  logic           is_wr;
  logic           is_rd;
  logic [NCH-1:0] dack_oh;
  logic [WCW-1:0] cur_cnt;
  logic [WCW-1:0] dec_cnt;
  logic           tc_fire;
  logic           abort;

  assign elig    = DREQ & ~mask & ~tc_mask_q;
  assign ch_type = xfer_type[{active_ch, 1'b0} +: 2];
  assign is_wr   = (ch_type == 2'b01);
  assign is_rd   = (ch_type == 2'b10);
  assign cur_cnt = count_q[active_ch];
  assign dec_cnt = cur_cnt - WCW'(1);
  // TC from count exhaustion or external EOP; a same-channel load suppresses it
  assign tc_fire = ((cur_cnt == '0) || eop_latch_q || !EOP_N_IN) && !wc_load[active_ch];
  assign abort   = !HLDA && (state_q inside {StS1, StS2, StS3});

  // Arbitration: fixed starts at ch0, rotating starts one past the last serviced
  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    idx       = '0;
    start     = rot_pri ? rot_ptr_q + 2'd1 : 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!win_valid && elig[idx]) begin
        win       = idx;
        win_valid = 1'b1;
      end
    end
  end

  // One-hot acknowledge for the latched channel
  always_comb begin
    dack_oh            = '0;
    dack_oh[active_ch] = 1'b1;
  end

  // Transfer FSM with registered outputs, plus word-count and TC bookkeeping
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StSi;
      HRQ         <= 1'b0;
      DACK        <= '0;
      aen         <= 1'b0;
      adstb       <= 1'b0;
      ior         <= 1'b1;
      iow         <= 1'b1;
      memr        <= 1'b1;
      memw        <= 1'b1;
      eop         <= 1'b1;
      addr_step   <= 1'b0;
      active_ch   <= '0;
      tc_status   <= '0;
      tc_mask_q   <= '0;
      rot_ptr_q   <= 2'd3;
      eop_latch_q <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        count_q[i] <= '0;
`ifdef DMA_AUTOINIT_EN
        base_q[i]  <= '0;
`endif
      end
    end else begin
      if (abort || state_q == StS4) begin
        // Completion or HLDA loss: everything returns inactive in SI
        if (state_q == StS4) rot_ptr_q <= active_ch;
        state_q     <= StSi;
        HRQ         <= 1'b0;
        DACK        <= '0;
        aen         <= 1'b0;
        adstb       <= 1'b0;
        ior         <= 1'b1;
        iow         <= 1'b1;
        memr        <= 1'b1;
        memw        <= 1'b1;
        eop         <= 1'b1;
        addr_step   <= 1'b0;
        eop_latch_q <= 1'b0;
      end else begin
        unique case (state_q)
          StSi: begin
            if (win_valid) begin
              active_ch <= win;
              HRQ       <= 1'b1;
              state_q   <= StS0;
            end
          end
          StS0: begin
            if (HLDA) begin
              aen     <= 1'b1;
              adstb   <= 1'b1;
              DACK    <= dack_oh;
              state_q <= StS1;
            end
          end
          StS1: begin
            adstb   <= 1'b0;
            ior     <= !is_wr;
            memr    <= !is_rd;
            state_q <= StS2;
          end
          StS2: begin
            if (!EOP_N_IN) eop_latch_q <= 1'b1;
            memw    <= !is_wr;
            iow     <= !is_rd;
            state_q <= StS3;
          end
          StS3: begin
            addr_step          <= 1'b1;
            eop_latch_q        <= 1'b0;
            count_q[active_ch] <= dec_cnt;
            if (tc_fire) begin
              eop                  <= 1'b0;
              tc_status[active_ch] <= 1'b1;
`ifdef DMA_AUTOINIT_EN
              if (autoinit[active_ch]) count_q[active_ch] <= base_q[active_ch];
              else                     tc_mask_q[active_ch] <= 1'b1;
`else
              tc_mask_q[active_ch] <= 1'b1;
`endif
            end
            state_q <= StS4;
          end
          default: state_q <= StSi;
        endcase
      end
      // Loads come last so they override any same-cycle decrement or TC
      for (int unsigned i = 0; i < NCH; i++) begin
        if (wc_load[i]) begin
          count_q[i]   <= wc_data;
          tc_mask_q[i] <= 1'b0;
          tc_status[i] <= 1'b0;
`ifdef DMA_AUTOINIT_EN
          base_q[i]    <= wc_data;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_xfer_sequencer.sv
// Directed self-checking bench for dma_xfer_sequencer.
module tb_dma_xfer_sequencer;

  logic       CLK = 1'b0;
  logic       RESET, HLDA, EOP_N_IN, rot_pri;
  logic [3:0] DREQ, mask, wc_load;
  logic [7:0] xfer_type;
  logic [15:0] wc_data;
`ifdef DMA_AUTOINIT_EN
  logic [3:0] autoinit;
`endif
  logic       HRQ, aen, adstb, ior, iow, memr, memw, eop, addr_step;
  logic [3:0] DACK, tc_status;
  logic [1:0] active_ch;
  logic [3:0] strb;

  int n_checks = 0;
  int n_errors = 0;

  assign strb = {ior, iow, memr, memw};

  dma_xfer_sequencer dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .EOP_N_IN(EOP_N_IN),
    .mask(mask), .rot_pri(rot_pri), .xfer_type(xfer_type), .wc_load(wc_load),
    .wc_data(wc_data),
`ifdef DMA_AUTOINIT_EN
    .autoinit(autoinit),
`endif
    .HRQ(HRQ), .DACK(DACK), .aen(aen), .adstb(adstb), .ior(ior), .iow(iow),
    .memr(memr), .memw(memw), .eop(eop), .tc_status(tc_status),
    .addr_step(addr_step), .active_ch(active_ch)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle away from the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; DREQ = '0; HLDA = 1'b0; EOP_N_IN = 1'b1; mask = '0; rot_pri = 1'b0;
    xfer_type = '0; wc_load = '0; wc_data = '0;
`ifdef DMA_AUTOINIT_EN
    autoinit = '0;
`endif
    tick(); tick();
    RESET = 1'b0;
  endtask

  task automatic load(input int ch, input logic [15:0] val);
    wc_load = 4'b0001 << ch; wc_data = val;
    tick();
    wc_load = '0;
  endtask

  // {ior,iow,memr,memw}: source strobe from S2, destination added from S3
  function automatic logic [3:0] exp_strb(input logic [1:0] ty, input logic dst);
    if (ty == 2'b01) return dst ? 4'b0110 : 4'b0111;
    if (ty == 2'b10) return dst ? 4'b1001 : 4'b1101;
    return 4'hF;
  endfunction

  // One full transfer starting from SI with the request pending and HLDA high
  task automatic xfer(input int ch, input logic [1:0] ty, input logic exp_eop,
                      input logic eop_s3);
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    tick(); check_eq("s0_hrq", HRQ, 1); check_eq("s0_ch", active_ch, ch);
    check_eq("s0_aen", aen, 0);
    tick(); check_eq("s1_aen_adstb", {aen, adstb}, 2'b11); check_eq("s1_dack", DACK, oh);
    check_eq("s1_strb", strb, 4'hF);
    tick(); check_eq("s2_adstb", adstb, 0); check_eq("s2_strb", strb, exp_strb(ty, 0));
    if (eop_s3) EOP_N_IN = 1'b0;
    tick(); check_eq("s3_strb", strb, exp_strb(ty, 1));
    EOP_N_IN = 1'b1;
    tick(); check_eq("s4_strb", strb, exp_strb(ty, 1)); check_eq("s4_step", addr_step, 1);
    check_eq("s4_eop", eop, exp_eop);
    tick();
    check_eq("si_idle", {HRQ, aen, adstb, DACK, strb, eop, addr_step},
             {1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 1'b1, 1'b0});
  endtask

  initial begin
    do_reset();
    check_eq("rst_outs", {HRQ, DACK, aen, adstb, strb, eop, addr_step, active_ch, tc_status},
             {1'b0, 4'h0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0});

    // ch1 write, count 2 -> three transfers, TC on the third
    xfer_type = 8'b00_00_01_00;
    load(1, 16'd2);
    DREQ = 4'b0010; HLDA = 1'b1;
    xfer(1, 2'b01, 1, 0);
    xfer(1, 2'b01, 1, 0);
    xfer(1, 2'b01, 0, 0);
    check_eq("t1_tc", tc_status, 4'b0010);
    tick(); tick();
    check_eq("t1_masked", HRQ, 0);

    // Masked channel is not eligible
    do_reset();
    mask = 4'b0001; DREQ = 4'b0001;
    tick(); tick();
    check_eq("mask_hrq", HRQ, 0);

    // Fixed priority: ch0 wins four times
    do_reset();
    wc_load = 4'hF; wc_data = 16'd5; tick(); wc_load = '0;
    DREQ = 4'hF; HLDA = 1'b1;
    for (int i = 0; i < 4; i++) xfer(0, 2'b00, 1, 0);

    // Rotating priority from reset: 0,1,2,3,0
    do_reset();
    wc_load = 4'hF; wc_data = 16'd5; tick(); wc_load = '0;
    DREQ = 4'hF; HLDA = 1'b1; rot_pri = 1'b1;
    for (int i = 0; i < 5; i++) xfer(i % 4, 2'b00, 1, 0);

    // ch2 read with HLDA low for 10 cycles in S0
    do_reset();
    xfer_type = 8'b00_10_00_00;
    load(2, 16'd3);
    DREQ = 4'b0100;
    tick(); check_eq("s0w_ch", active_ch, 2);
    for (int i = 0; i < 10; i++) begin
      check_eq("s0w_hold", {HRQ, aen, DACK, strb}, {1'b1, 1'b0, 4'h0, 4'hF});
      tick();
    end
    HLDA = 1'b1;
    tick(); check_eq("s0w_s1", {aen, adstb, DACK}, {1'b1, 1'b1, 4'b0100});
    tick(); check_eq("s0w_s2", strb, 4'b1101);
    tick(); check_eq("s0w_s3", strb, 4'b1001);
    tick(); check_eq("s0w_s4", {eop, addr_step}, 2'b11);
    tick(); check_eq("s0w_si", {HRQ, strb}, {1'b0, 4'hF});

    // External EOP in S3 of ch0 (count 7)
    do_reset();
    load(0, 16'd7);
    DREQ = 4'b0001; HLDA = 1'b1;
    xfer(0, 2'b00, 0, 1);
    check_eq("eop_tc", tc_status, 4'b0001);
    check_eq("eop_cnt", dut.count_q[0], 16'd6);
    tick(); tick();
    check_eq("eop_masked", HRQ, 0);

    // HLDA drop in S2 aborts without decrement: count 0 still fires TC next time
    do_reset();
    xfer_type = 8'b00_00_00_01;
    DREQ = 4'b0001; HLDA = 1'b1;
    tick(); tick(); tick();
    check_eq("ab_s2", strb, 4'b0111);
    HLDA = 1'b0;
    tick();
    check_eq("ab_idle", {HRQ, aen, DACK, strb, eop, tc_status},
             {1'b0, 1'b0, 4'h0, 4'hF, 1'b1, 4'h0});
    HLDA = 1'b1;
    xfer(0, 2'b01, 0, 0);
    check_eq("ab_tc", tc_status, 4'b0001);

    // RESET asserted in S3
    load(1, 16'd4);
    DREQ = 4'b0010;
    tick(); tick(); tick(); tick();
    check_eq("rs_s3", {aen, active_ch}, {1'b1, 2'd1});
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check_eq("rs_outs", {HRQ, DACK, aen, adstb, strb, eop, addr_step, active_ch, tc_status},
             {1'b0, 4'h0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0});

    // Load sampled on the S4-entry edge of the active channel wins over TC
    do_reset();
    DREQ = 4'b0100; HLDA = 1'b1;
    tick(); tick(); tick(); tick();
    wc_load = 4'b0100; wc_data = 16'd3;
    tick();
    wc_load = '0;
    check_eq("lw_eop", {eop, tc_status}, {1'b1, 4'h0});
    tick();
    check_eq("lw_cnt", dut.count_q[2], 16'd3);

`ifdef DMA_AUTOINIT_EN
    // Autoinit on ch3: count 1 -> two transfers, reload, still serviceable
    do_reset();
    autoinit = 4'b1000;
    load(3, 16'd1);
    DREQ = 4'b1000; HLDA = 1'b1;
    xfer(3, 2'b00, 1, 0);
    xfer(3, 2'b00, 0, 0);
    check_eq("ai_tc", tc_status, 4'b1000);
    check_eq("ai_cnt", dut.count_q[3], 16'd1);
    xfer(3, 2'b00, 1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dma_xfer_sequencer.md
Name: dma_xfer_sequencer

Overview:
- Control FSM for the four-channel 8237-style DMA datapath.
- Arbitrates DREQ[3:0], runs the HRQ/HLDA bus handshake, and steps the SI/S0/S1/S2/S3/S4 transfer states.
- Drives the datapath control nets: aen, adstb, ior, iow, memr, memw, eop.
- Holds each channel's current word count and generates terminal count (TC).

Parameters:
- NCH, 4, number of channels (the logic is written for 4).
- WCW, 16, word-count width.

Ports:
- CLK  in  1  system clock; every flop updates on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- DREQ  in  4  channel requests, active-high, level-sensitive.
- HLDA  in  1  hold acknowledge from the CPU.
- EOP_N_IN  in  1  external end-of-process, active-low.
- mask  in  4  programmed channel masks; 1 = disabled.
- rot_pri  in  1  0 = fixed priority (ch0 highest), 1 = rotating priority.
- xfer_type  in  8  2 bits per channel: 00 verify, 01 write (IO->mem), 10 read (mem->IO), 11 treated as verify.
- wc_load  in  4  one-hot strobe: load that channel's count from wc_data.
- wc_data  in  16  word-count load value.
- HRQ  out  1  hold request to the CPU.
- DACK  out  4  channel acknowledge, active-high, one-hot.
- aen, adstb  out  1 each  address enable and upper-address strobe.
- ior, iow, memr, memw  out  1 each  active-low command strobes.
- eop  out  1  active-low TC pulse, driven on the EOP pin only in the active cycle.
- tc_status  out  4  sticky per-channel TC flags.
- addr_step  out  1  one-cycle pulse telling the address logic to increment.
- active_ch  out  2  channel currently being serviced.

Behaviour:
- Reset values: state SI; HRQ=0; DACK=0; aen=0; adstb=0; ior=iow=memr=memw=1; eop=1; addr_step=0; active_ch=0; tc_status=0; all word counts=0; internal tc_mask=0.
- Eligible channels: DREQ & ~mask & ~tc_mask.
- SI:
  - If any channel is eligible: latch the winner into active_ch, set HRQ=1, go to S0.
  - Otherwise stay in SI.
- S0: hold HRQ=1; go to S1 on HLDA=1; wait indefinitely otherwise.
- S1: aen=1, adstb=1, DACK[active_ch]=1.
- S2:
  - adstb=0; aen and DACK stay high.
  - Source strobe low: write → ior; read → memr; verify → none.
- S3: source strobe stays low; destination strobe low (write → memw, read → iow).
- S4:
  - Both strobes stay low; addr_step=1.
  - Decrement the active channel's count; 0 wraps to FFFF.
  - If the pre-decrement count was 0, or an external EOP was latched: eop=0 this cycle only, set tc_status[ch] and tc_mask[ch].
- Exit from S4: go to SI next cycle (single-transfer mode). HRQ, aen, DACK and all strobes return inactive on entry to SI.
- Transfer length: a count value N gives N+1 transfers before TC.
- Request timing:
  - DREQ is sampled only in SI; a DREQ drop after SI does not abort the transfer.
  - Minimum SI-to-SI latency with HLDA already high is 6 cycles.
- EOP_N_IN:
  - Sampled in S2 and S3; a low value there sets a latch that is consumed in S4.
  - Ignored in all other states.
- HLDA falling while in S1–S3: abort to SI next cycle with all outputs inactive, no decrement, no TC.
- Arbitration:
  - Fixed mode: lowest eligible index wins.
  - Rotating mode: priority starts at (last serviced + 1) mod 4.
  - The rotation pointer updates only on completion of S4; after reset it is 3, so ch0 is highest.
- wc_load[i]:
  - Writes count[i], clears tc_mask[i] and tc_status[i].
  - If it coincides with the S4 decrement of the same channel, the load wins and no TC fires.
  - Multiple wc_load bits high: every selected channel loads.
- Reset in any state returns to SI with reset values on the next edge.

Optional Feature:
- Macro: DMA_AUTOINIT_EN.
- Defined:
  - Adds input autoinit[3:0] and a 16-bit base register per channel, written alongside count by wc_load.
  - At TC on a channel with autoinit=1: count reloads from base instead of wrapping, tc_status is set, tc_mask is not set, and eop still pulses.
- Undefined: no autoinit port and no base registers; TC always sets tc_mask.

Test Plan:
- Load ch1 count=2, xfer_type=01, hold DREQ[1]=1 and HLDA=1 from S0 → three transfers (ior S2–S4, memw S3–S4 each); eop=0 in S4 of the third only; tc_status=0010; further DREQ[1] ignored.
- DREQ=1111, mask=0000, rot_pri=0, counts=5 → four consecutive services of ch0. With rot_pri=1 → service order 0,1,2,3,0.
- ch2 read transfer with HLDA held low for 10 cycles in S0 → HRQ=1 throughout; no strobes until HLDA rises; then S1 follows on the next cycle.
- EOP_N_IN=0 during S3 of ch0 (count=7) → eop=0 in S4, tc_status[0]=1, count=6, ch0 masked.
- HLDA drops in S2 → next cycle SI, all strobes high, count unchanged. RESET asserted in S3 → next cycle all reset values.
- With DMA_AUTOINIT_EN, ch3 autoinit=1, count=1 → two transfers; on the second, TC, count reloads to 1, tc_status[3]=1, ch3 still serviceable.
